spi_master_tx: RTL and testbench

- SPI initiator, clocked from the 27 MHz system clock. Serialises one byte per transaction onto spi_clk/spi_mosi and captures spi_miso in the same transaction.
- Wire format is the one the main SPI slave accepts:
  - spi_clk idles low.
  - spi_mosi changes on the spi_clk rising edge.
  - The slave samples on the falling edge.
  - 8 bits, LSB first, active-high chip select.
- Used to drive external SPI peripherals and for on-board loopback against the slave.

---
 rtl/spi_master_tx_if.sv | 41 ++++
 rtl/spi_master_tx.sv | 189 ++++++++++++++++++
 tb/tb_spi_master_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// Bus bundle for spi_master_tx: byte request/response handshake plus the SPI pins.
// The master modport is the SPI initiator; the slave modport is whoever feeds it
// bytes and drives spi_miso (the requester / the attached peripheral).
interface spi_master_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs;

  modport master (
    input  tx_data,
    input  tx_valid,
    input  spi_miso,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output busy,
    output spi_clk,
    output spi_mosi,
    output spi_cs
  );

  modport slave (
    output tx_data,
    output tx_valid,
    output spi_miso,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  spi_clk,
    input  spi_mosi,
    input  spi_cs
  );
endinterface

// File: rtl/spi_master_tx.sv
// Single-byte SPI initiator. spi_clk idles low, mosi changes on the spi_clk rise,
// miso is captured on the spi_clk fall, active-high chip select.
// Transaction: LEAD (2 half-periods), 8 x (BIT_HI, BIT_LO), TRAIL (2 half-periods),
// giving 20*HALF_DIV cycles of cs high. All outputs are registered.
// Build option: define SPI_TX_MSB_FIRST_EN to send/receive MSB first (default LSB first).
module spi_master_tx #(
  parameter int unsigned HALF_DIV = 9
) (
  input logic             clk,
  input logic             rst,
  spi_master_tx_if.master bus
);

  if (HALF_DIV < 2) begin : g_half_div_check
    $error("spi_master_tx: HALF_DIV must be at least 2");
  end

  localparam int unsigned CntW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CntW-1:0] HcntLast = CntW'(HALF_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLead  = 3'd1;
  localparam logic [2:0] StBitHi = 3'd2;
  localparam logic [2:0] StBitLo = 3'd3;
  localparam logic [2:0] StTrail = 3'd4;

  // Maps the serial bit number (0 = first on the wire) to a byte position.
`ifdef SPI_TX_MSB_FIRST_EN
  function automatic logic [2:0] bit_pos(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction
`else
  function automatic logic [2:0] bit_pos(input logic [2:0] idx);
    return idx;
  endfunction
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic            half_q, half_d;  // second half-period of LEAD/TRAIL
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_ready_q, tx_ready_d;
  logic            busy_q, busy_d;
  logic            spi_clk_q, spi_clk_d;
  logic            spi_mosi_q, spi_mosi_d;
  logic            spi_cs_q, spi_cs_d;
  logic            hcnt_done;

  assign hcnt_done = (hcnt_q == HcntLast);

  // Next-state: sequencing of the transaction phases and the registered pin values.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    half_d     = half_q;
    bit_idx_d  = bit_idx_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    spi_clk_d  = spi_clk_q;
    spi_mosi_d = spi_mosi_q;
    spi_cs_d   = spi_cs_q;

    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_sh_d   = bus.tx_data;
          spi_cs_d  = 1'b1;
          hcnt_d    = '0;
          half_d    = 1'b0;
          bit_idx_d = 3'd0;
          state_d   = StLead;
        end
      end
      StLead: begin
        if (hcnt_done) begin
          hcnt_d = '0;
          if (half_q) begin
            half_d     = 1'b0;
            spi_clk_d  = 1'b1;
            spi_mosi_d = tx_sh_q[bit_pos(3'd0)];
            state_d    = StBitHi;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + CntW'(1);
        end
      end
      StBitHi: begin
        if (hcnt_done) begin
          hcnt_d                     = '0;
          spi_clk_d                  = 1'b0;
          rx_sh_d[bit_pos(bit_idx_q)] = bus.spi_miso;
          state_d                    = StBitLo;
        end else begin
          hcnt_d = hcnt_q + CntW'(1);
        end
      end
      StBitLo: begin
        if (hcnt_done) begin
          hcnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            spi_mosi_d = 1'b0;
            half_d     = 1'b0;
            state_d    = StTrail;
          end else begin
            bit_idx_d  = bit_idx_q + 3'd1;
            spi_clk_d  = 1'b1;
            spi_mosi_d = tx_sh_q[bit_pos(bit_idx_q + 3'd1)];
            state_d    = StBitHi;
          end
        end else begin
          hcnt_d = hcnt_q + CntW'(1);
        end
      end
      StTrail: begin
        if (hcnt_done) begin
          hcnt_d = '0;
          if (half_q) begin
            half_d     = 1'b0;
            spi_cs_d   = 1'b0;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = StIdle;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Handshake flags follow the state being entered so they are registered too.
    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      hcnt_q     <= '0;
      half_q     <= 1'b0;
      bit_idx_q  <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      spi_clk_q  <= 1'b0;
      spi_mosi_q <= 1'b0;
      spi_cs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      half_q     <= half_d;
      bit_idx_q  <= bit_idx_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      spi_clk_q  <= spi_clk_d;
      spi_mosi_q <= spi_mosi_d;
      spi_cs_q   <= spi_cs_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.spi_mosi = spi_mosi_q;
  assign bus.spi_cs   = spi_cs_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx. A negedge monitor records each cs-high
// window (mosi seen at spi_clk falls, edge counts, timing) and plays a miso
// pattern changing on spi_clk rises. Serial patterns are stored in wire order:
// bit i = i-th bit on the wire.
module tb_spi_master_tx;
`ifdef SPI_TX_MSB_FIRST_EN
  localparam int HI = 2;
`else
  localparam int HI = 9;
`endif
  localparam int Bound = 40 * HI + 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_master_tx_if bus ();

  spi_master_tx #(
    .HALF_DIV(HI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mosi;
    int         cs_cyc;
    int         first_rise;
    int         rises;
    int         falls;
    int         gap;
  } rec_t;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
  } vec_t;

  rec_t       rec_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_cyc = -100;
  int         rxv_cyc = -100;
  int         fall_cyc = -100;
  int         busy_bad = 0;
  int         cur_rises = 0;
  bit         mon_en = 1'b0;
  logic       prev_clk = 1'b0;
  logic       prev_cs = 1'b0;
  rec_t       cur;
  logic [7:0] cur_miso = 8'h00;

  // Byte <-> wire-order conversion for the build under test.
  function automatic logic [7:0] ord(input logic [7:0] b);
    logic [7:0] r;
`ifdef SPI_TX_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and miso responder.
  always @(negedge clk) begin
    cyc++;
    if (!mon_en) begin
      bus.spi_miso = 1'b0;
    end else begin
      if (bus.busy !== bus.spi_cs || bus.tx_ready !== ~bus.spi_cs) busy_bad++;
      if (bus.tx_valid && bus.tx_ready) acc_cyc = cyc;
      if (bus.rx_valid) begin
        rx_q.push_back(bus.rx_data);
        rxv_cyc = cyc;
      end
      if (bus.spi_cs && !prev_cs) begin
        cur = '{mosi: 8'h00, cs_cyc: 0, first_rise: -1, rises: 0, falls: 0,
                gap: cyc - fall_cyc};
        cur_rises = 0;
        cur_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
      end
      if (bus.spi_cs) begin
        cur.cs_cyc++;
        if (bus.spi_clk && !prev_clk) begin
          if (cur.rises == 0) cur.first_rise = cyc - acc_cyc;
          if (cur.rises < 8) bus.spi_miso = cur_miso[cur.rises];
          cur.rises++;
          cur_rises = cur.rises;
        end
        if (!bus.spi_clk && prev_clk) begin
          if (cur.falls < 8) cur.mosi[cur.falls] = bus.spi_mosi;
          cur.falls++;
        end
      end
      if (!bus.spi_cs && prev_cs) begin
        rec_q.push_back(cur);
        fall_cyc = cyc;
        cur_rises = 0;
        bus.spi_miso = 1'b0;
      end
    end
    prev_clk = bus.spi_clk;
    prev_cs  = bus.spi_cs;
  end

  // Presents a byte with tx_valid high and returns just after the accepting edge.
  // tx_valid is left high; the caller drops it.
  task automatic send(input logic [7:0] d, input logic [7:0] mseq);
    bit done;
    done = 1'b0;
    miso_q.push_back(mseq);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < Bound && !done; i++) begin
      if (bus.tx_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_xfer(input string name, input logic [7:0] exp_mosi,
                            input logic [7:0] exp_rx, output int gap);
    rec_t r;
    int   n;
    n = 0;
    gap = -1;
    while (rec_q.size() == 0 && n < Bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rec_q.size() == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    repeat (2) @(posedge clk);
    #1;
    r = rec_q.pop_front();
    gap = r.gap;
    chk({name, "_mosi"}, r.mosi, exp_mosi);
    chk({name, "_cs_cycles"}, r.cs_cyc, 20 * HI);
    chk({name, "_first_rise"}, r.first_rise, 2 * HI + 1);
    chk({name, "_rises"}, r.rises, 8);
    chk({name, "_falls"}, r.falls, 8);
    chk({name, "_rxv_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({name, "_rx_data"}, rx_q.pop_front(), exp_rx);
    rx_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t vecs[4];
    int   g;
    int   bad;
    int   n;

`ifdef SPI_TX_MSB_FIRST_EN
    vecs[0] = '{tx: 8'h02, miso: 8'hA5, exp_mosi: 8'h40, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'h80, miso: 8'h01, exp_mosi: 8'h01, exp_rx: 8'h80};
    vecs[2] = '{tx: 8'hC1, miso: 8'h0F, exp_mosi: 8'h83, exp_rx: 8'hF0};
    vecs[3] = '{tx: 8'hFF, miso: 8'h00, exp_mosi: 8'hFF, exp_rx: 8'h00};
`else
    vecs[0] = '{tx: 8'h5A, miso: 8'hC3, exp_mosi: 8'h5A, exp_rx: 8'hC3};
    vecs[1] = '{tx: 8'hA0, miso: 8'h81, exp_mosi: 8'hA0, exp_rx: 8'h81};
    vecs[2] = '{tx: 8'h00, miso: 8'hFF, exp_mosi: 8'h00, exp_rx: 8'hFF};
    vecs[3] = '{tx: 8'hFF, miso: 8'h00, exp_mosi: 8'hFF, exp_rx: 8'h00};
`endif

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_tx_ready", bus.tx_ready, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rx_valid", bus.rx_valid, 0);
    chk("reset_rx_data", bus.rx_data, 8'h00);
    chk("reset_spi_clk", bus.spi_clk, 0);
    chk("reset_spi_mosi", bus.spi_mosi, 0);
    chk("reset_spi_cs", bus.spi_cs, 0);
    mon_en = 1'b1;

    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.tx_ready !== 1'b1 || bus.spi_cs !== 1'b0 || bus.spi_clk !== 1'b0 ||
          bus.spi_mosi !== 1'b0 || bus.rx_valid !== 1'b0) bad++;
    end
    chk("idle_stable", bad, 0);

    foreach (vecs[i]) begin
      send(vecs[i].tx, vecs[i].miso);
      bus.tx_valid = 1'b0;
      check_xfer($sformatf("vec%0d", i), vecs[i].exp_mosi, vecs[i].exp_rx, g);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back with tx_valid held: second byte taken in the rx_valid cycle.
    send(8'h01, 8'h96);
    send(8'hFF, 8'h3C);
    bus.tx_valid = 1'b0;
    chk("b2b_accept_on_rxv", acc_cyc, rxv_cyc);
    check_xfer("b2b0", ord(8'h01), ord(8'h96), g);
    check_xfer("b2b1", ord(8'hFF), ord(8'h3C), g);
    chk("b2b_cs_gap", g, 1);
    repeat (3) @(posedge clk);
    #1;

    // tx_data changes while busy with tx_valid held: not re-latched mid-transfer.
    send(8'h11, 8'h5A);
    repeat (5 * HI) @(posedge clk);
    #1;
    bus.tx_data = 8'hDF;
    send(8'hDF, 8'h77);
    bus.tx_valid = 1'b0;
    check_xfer("hold0", ord(8'h11), ord(8'h5A), g);
    check_xfer("hold1", ord(8'hDF), ord(8'h77), g);
    repeat (3) @(posedge clk);
    #1;

    // Reset during bit 4 of 8'h05.
    send(8'h05, 8'hE1);
    bus.tx_valid = 1'b0;
    n = 0;
    while (cur_rises < 5 && n < Bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_reached_bit4", cur_rises, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_spi_cs", bus.spi_cs, 0);
    chk("rst_spi_clk", bus.spi_clk, 0);
    chk("rst_spi_mosi", bus.spi_mosi, 0);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    repeat (30 * HI) @(posedge clk);
    #1;
    chk("rst_no_rxv", rx_q.size(), 0);
    rec_q.delete();
    rx_q.delete();

    send(8'h03, 8'hB4);
    bus.tx_valid = 1'b0;
    check_xfer("post_rst", ord(8'h03), ord(8'hB4), g);

    repeat (5) @(posedge clk);
    #1;
    chk("busy_ready_track_cs", busy_bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
